seq_match_ctrl: RTL and testbench

- Programmable controller for character-stream sequence detection on the valid-qualified 8-bit byte bus.
- Holds a configurable PLEN-character pattern and arms/disarms matching under start/abort.
- Selects overlapping or non-overlapping match policy, counts matches and stops after a programmed target count.
- Sits between the host configuration interface and the byte stream source, replacing fixed-pattern hard-coded detectors.

---
 rtl/seq_match_ctrl_if.sv | 36 +++
 rtl/seq_match_ctrl.sv | 153 +++++++++++++++
 tb/tb_seq_match_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_match_ctrl_if.sv
// Bus bundle for seq_match_ctrl.
// Carries the host configuration and control inputs, the valid-qualified byte stream, and the
// controller status outputs.
// master: host/stream side (drives config, control and stream).
// slave : controller side (drives busy, seq_dec, match_cnt, done).
interface seq_match_ctrl_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned PLEN  = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned AW = (PLEN > 1) ? $clog2(PLEN) : 1;

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [DW-1:0]    cfg_data;
    logic             overlap;
    logic [CNT_W-1:0] target;
    logic             start;
    logic             abort;
    logic             valid;
    logic [DW-1:0]    data_in;
    logic             busy;
    logic             seq_dec;
    logic [CNT_W-1:0] match_cnt;
    logic             done;

    modport master (
        output cfg_we, cfg_addr, cfg_data, overlap, target, start, abort, valid, data_in,
        input  busy, seq_dec, match_cnt, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, overlap, target, start, abort, valid, data_in,
        output busy, seq_dec, match_cnt, done
    );
endinterface

// File: rtl/seq_match_ctrl.sv
// Programmable sequence-match controller.
// It detects a programmable PLEN-character pattern on a valid-qualified byte stream.
// The match policy can be overlapping or non-overlapping.
// It counts matches and stops after a programmed target count.
// Ports:
//   clk  : clock, rising edge.
//   rst  : asynchronous active-high reset.
//   bus  : slave modport of seq_match_ctrl_if, which carries:
//            - configuration: cfg_we, cfg_addr, cfg_data
//            - control: overlap, target, start, abort
//            - stream: valid, data_in
//            - status: busy, seq_dec, match_cnt, done
module seq_match_ctrl #(
    parameter int unsigned DW    = 8,
    parameter int unsigned PLEN  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_match_ctrl_if.slave   bus
);
    localparam int unsigned AW = (PLEN > 1) ? $clog2(PLEN) : 1;
    localparam int unsigned FW = $clog2(PLEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    pat_q      [PLEN];
    logic [DW-1:0]    hist_q     [PLEN];
    logic [DW-1:0]    hist_d     [PLEN];
    logic [DW-1:0]    hist_shift [PLEN];
    logic [FW-1:0]    fill_q, fill_d, fill_inc;
    logic             overlap_q, overlap_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             busy_q, busy_d;
    logic             seq_dec_q, seq_dec_d;
    logic             done_q, done_d;
    logic             arm, accept, hit, match, reach;

    // Power-up pattern: "BCCB" for the 4-character build, all zeros otherwise.
    function automatic logic [DW-1:0] rst_char(input int unsigned idx);
        if (PLEN != 4) return '0;
        return (idx == 0 || idx == 3) ? DW'(8'h42) : DW'(8'h43);
    endfunction

    // Shifted history and match test on the post-shift view.
    always_comb begin
        for (int i = 0; i < int'(PLEN) - 1; i++) begin
            hist_shift[AW'(i)] = hist_q[AW'(i + 1)];
        end
        hist_shift[AW'(PLEN - 1)] = bus.data_in;
        fill_inc = (fill_q == FW'(PLEN)) ? fill_q : fill_q + FW'(1);
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        hit      = (fill_inc == FW'(PLEN));
        for (int i = 0; i < int'(PLEN); i++) begin
            if (hist_shift[AW'(i)] != pat_q[AW'(i)]) hit = 1'b0;
        end
    end

    // Abort dominates start; start is only meaningful outside ARMED.
    assign arm    = (state_q != ARMED) && bus.start && !bus.abort;
    assign accept = (state_q == ARMED) && !bus.abort && bus.valid;
    assign match  = accept && hit;
    assign reach  = match && (target_q != '0) && (cnt_inc == target_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (arm) state_d = ARMED;
            ARMED: begin
                if (bus.abort)  state_d = IDLE;
                else if (reach) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and matcher datapath.
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        overlap_d = overlap_q;
        target_d  = target_q;
        done_d    = done_q;
        seq_dec_d = 1'b0;
        busy_d    = (state_d == ARMED);
        if (arm) begin
            for (int i = 0; i < int'(PLEN); i++) hist_d[AW'(i)] = '0;
            fill_d    = '0;
            cnt_d     = '0;
            done_d    = 1'b0;
            overlap_d = bus.overlap;
            target_d  = bus.target;
        end else if (accept) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (hit) begin
                seq_dec_d = 1'b1;
                cnt_d     = cnt_inc;
                // Non-overlap: the next match must be built from fresh characters.
                if (!overlap_q) fill_d = '0;
                if (reach)      done_d = 1'b1;
            end
        end
    end

    // Datapath and output registers; pattern writes are locked out while ARMED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(PLEN); i++) begin
                pat_q[AW'(i)]  <= rst_char(i);
                hist_q[AW'(i)] <= '0;
            end
            fill_q    <= '0;
            cnt_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
            done_q    <= 1'b0;
            seq_dec_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (bus.cfg_we && state_q != ARMED && int'(bus.cfg_addr) < int'(PLEN)) begin
                pat_q[bus.cfg_addr] <= bus.cfg_data;
            end
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            overlap_q <= overlap_d;
            target_q  <= target_d;
            done_q    <= done_d;
            seq_dec_q <= seq_dec_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.seq_dec   = seq_dec_q;
    assign bus.match_cnt = cnt_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed, table-driven bench for seq_match_ctrl.
// Each table row holds one cycle of stimulus and the expected outputs after that edge.
// Hand-written sequences then cover asynchronous reset while the matcher is armed.
module tb_seq_match_ctrl;
    localparam int unsigned DW    = 8;
    localparam int unsigned PLEN  = 4;
    localparam int unsigned CNT_W = 8;

    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [7:0] CH_B = 8'h42;
    localparam logic [7:0] CH_C = 8'h43;
    localparam logic [7:0] CH_X = 8'h78;

    typedef struct {
        logic       st;
        logic       ab;
        logic       ov;
        logic [7:0] tg;
        logic       vl;
        logic [7:0] d;
        logic       we;
        logic [1:0] a;
        logic [7:0] cd;
        logic       eb;
        logic       es;
        logic [7:0] ec;
        logic       ed;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];

    seq_match_ctrl_if #(.DW(DW), .PLEN(PLEN), .CNT_W(CNT_W)) bus ();

    seq_match_ctrl #(.DW(DW), .PLEN(PLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, ab, ov, input logic [7:0] tg, input logic vl,
                                input logic [7:0] d, input logic we, input logic [1:0] a,
                                input logic [7:0] cd, input logic eb, es,
                                input logic [7:0] ec, input logic ed);
        vec_t v;
        v.st = st; v.ab = ab; v.ov = ov; v.tg = tg; v.vl = vl; v.d = d;
        v.we = we; v.a = a; v.cd = cd;
        v.eb = eb; v.es = es; v.ec = ec; v.ed = ed;
        return v;
    endfunction

    // Start pulse with policy/target.
    function automatic vec_t s(input logic ov, input logic [7:0] tg,
                               input logic eb, es, input logic [7:0] ec, input logic ed);
        return mk(1, 0, ov, tg, 0, 8'h00, 0, 2'd0, 8'h00, eb, es, ec, ed);
    endfunction

    // One valid stream character.
    function automatic vec_t d(input logic [7:0] ch,
                               input logic eb, es, input logic [7:0] ec, input logic ed);
        return mk(0, 0, 0, 8'h00, 1, ch, 0, 2'd0, 8'h00, eb, es, ec, ed);
    endfunction

    // Abort pulse, optionally with start.
    function automatic vec_t ab(input logic st,
                                input logic eb, es, input logic [7:0] ec, input logic ed);
        return mk(st, 1, 0, 8'h00, 0, 8'h00, 0, 2'd0, 8'h00, eb, es, ec, ed);
    endfunction

    // Pattern write.
    function automatic vec_t w(input logic [1:0] a, input logic [7:0] cd,
                               input logic eb, es, input logic [7:0] ec, input logic ed);
        return mk(0, 0, 0, 8'h00, 0, 8'h00, 1, a, cd, eb, es, ec, ed);
    endfunction

    task automatic check(input string name, input logic eb, es, input logic [7:0] ec,
                         input logic ed);
        n_checks++;
        if ({bus.busy, bus.seq_dec, bus.match_cnt, bus.done} !== {eb, es, ec, ed}) begin
            n_fail++;
            $display("FAIL %s: got busy=%0b seq_dec=%0b match_cnt=%0d done=%0b, want busy=%0b seq_dec=%0b match_cnt=%0d done=%0b",
                     name, bus.busy, bus.seq_dec, bus.match_cnt, bus.done, eb, es, ec, ed);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.start = v.st; bus.abort = v.ab; bus.overlap = v.ov; bus.target = v.tg;
        bus.valid = v.vl; bus.data_in = v.d;
        bus.cfg_we = v.we; bus.cfg_addr = v.a; bus.cfg_data = v.cd;
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check(name, v.eb, v.es, v.ec, v.ed);
    endtask

    task automatic idle_inputs();
        drive(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 2'd0, 8'h00, 0, 0, 8'h00, 0));
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // 1: default pattern BCCB, non-overlap, unlimited.
        tbl.push_back(s(0, 8'd0, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_B, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_B, 1, 1, 8'd1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 2'd0, 8'h00, 1, 0, 8'd1, 0));
        // 2: BCCBCCB with overlap -> two pulses.
        tbl.push_back(ab(0, 0, 0, 8'd1, 0));
        tbl.push_back(s(1, 8'd0, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_B, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_B, 1, 1, 8'd1, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd1, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd1, 0));
        tbl.push_back(d(CH_B, 1, 1, 8'd2, 0));
        // Same stream without overlap -> one pulse.
        tbl.push_back(ab(0, 0, 0, 8'd2, 0));
        tbl.push_back(s(0, 8'd0, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_B, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_B, 1, 1, 8'd1, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd1, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd1, 0));
        tbl.push_back(d(CH_B, 1, 0, 8'd1, 0));
        tbl.push_back(ab(0, 0, 0, 8'd1, 0));
        // 3: target=2, BCCBxBCCBBCCB.
        tbl.push_back(s(0, 8'd2, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_B, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_B, 1, 1, 8'd1, 0));
        tbl.push_back(d(CH_X, 1, 0, 8'd1, 0));
        tbl.push_back(d(CH_B, 1, 0, 8'd1, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd1, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd1, 0));
        tbl.push_back(d(CH_B, 0, 1, 8'd2, 1));
        tbl.push_back(d(CH_B, 0, 0, 8'd2, 1));
        tbl.push_back(d(CH_C, 0, 0, 8'd2, 1));
        tbl.push_back(d(CH_C, 0, 0, 8'd2, 1));
        tbl.push_back(d(CH_B, 0, 0, 8'd2, 1));
        // 4: abort mid-sequence, start+abort combinations, start while armed.
        tbl.push_back(s(0, 8'd0, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_B, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(ab(0, 0, 0, 8'd0, 0));
        tbl.push_back(d(CH_B, 0, 0, 8'd0, 0));
        tbl.push_back(ab(1, 0, 0, 8'd0, 0));
        tbl.push_back(s(0, 8'd0, 1, 0, 8'd0, 0));
        tbl.push_back(ab(1, 0, 0, 8'd0, 0));
        tbl.push_back(s(0, 8'd0, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_B, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, CH_B, 0, 2'd0, 8'h00, 1, 1, 8'd1, 0));
        tbl.push_back(ab(0, 0, 0, 8'd1, 0));
        // 5: program ABCA, overlap; write while armed is ignored.
        tbl.push_back(w(2'd0, CH_A, 0, 0, 8'd1, 0));
        tbl.push_back(w(2'd1, CH_B, 0, 0, 8'd1, 0));
        tbl.push_back(w(2'd2, CH_C, 0, 0, 8'd1, 0));
        tbl.push_back(w(2'd3, CH_A, 0, 0, 8'd1, 0));
        tbl.push_back(s(1, 8'd0, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_A, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_B, 1, 0, 8'd0, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, CH_A, 1, 2'd1, 8'h5A, 1, 1, 8'd1, 0));
        tbl.push_back(d(CH_B, 1, 0, 8'd1, 0));
        tbl.push_back(d(CH_C, 1, 0, 8'd1, 0));
        tbl.push_back(d(CH_A, 1, 1, 8'd2, 0));
        tbl.push_back(ab(0, 0, 0, 8'd2, 0));

        #3;
        check("reset_state", 0, 0, 8'd0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Async reset while armed with three matches counted and target 4 pending.
        apply(s(1, 8'd4, 1, 0, 8'd0, 0), "arm_t4");
        for (int k = 0; k < 3; k++) begin
            apply(d(CH_A, 1, (k != 0), 8'(k), 0), $sformatf("rs_a%0d", k));
            apply(d(CH_B, 1, 0, 8'(k), 0), $sformatf("rs_b%0d", k));
            apply(d(CH_C, 1, 0, 8'(k), 0), $sformatf("rs_c%0d", k));
        end
        apply(d(CH_A, 1, 1, 8'd3, 0), "rs_cnt3");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", 0, 0, 8'd0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Pattern must be back to BCCB: ABCA no longer matches, BCCB does.
        apply(s(0, 8'd0, 1, 0, 8'd0, 0), "post_rst_start");
        apply(d(CH_A, 1, 0, 8'd0, 0), "pr_a0");
        apply(d(CH_B, 1, 0, 8'd0, 0), "pr_b0");
        apply(d(CH_C, 1, 0, 8'd0, 0), "pr_c0");
        apply(d(CH_A, 1, 0, 8'd0, 0), "pr_abca_nomatch");
        apply(d(CH_B, 1, 0, 8'd0, 0), "pr_b1");
        apply(d(CH_C, 1, 0, 8'd0, 0), "pr_c1");
        apply(d(CH_C, 1, 0, 8'd0, 0), "pr_c2");
        apply(d(CH_B, 1, 1, 8'd1, 0), "pr_bccb_match");
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("pr_pulse_clears", 1, 0, 8'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
